// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if : operation/result bus between the decode stage and alu_seq.
//
// Handshake: an operation is transferred on a rising clock edge where both
// in_valid and in_ready are high. The master may hold or change its payload
// freely while in_ready is low; nothing is sampled then. The result side has
// no backpressure: out_valid is a one-cycle pulse and result/flags hold
// until the next pulse.
//
// Signals
//   in_valid   master -> slave  operation presented
//   in_ready   slave  -> master slave can accept this cycle
//   opcode     master -> slave  8-bit operation code
//   a, b       master -> slave  operands (b[SHW-1:0] doubles as shift count)
//   out_valid  slave  -> master result/flags updated this cycle
//   result     slave  -> master last result
//   flags      slave  -> master {Z,C,F,N,L}
//   illegal    slave  -> master undefined opcode, pulses with out_valid
//   state_dbg  slave  -> master sequencer state (debug observation)
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;
    logic             illegal;
    logic [1:0]       state_dbg;

    modport master (
        output in_valid, opcode, a, b,
        input  in_ready, out_valid, result, flags, illegal, state_dbg
    );

    modport slave (
        input  in_valid, opcode, a, b,
        output in_ready, out_valid, result, flags, illegal, state_dbg
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered sequential ALU owning the ZCFNL flag register.
//
// One operation is accepted per handshake. Single-cycle operations are
// captured on the accept edge and executed on the following edge, so
// back-to-back issue yields one result per clock and ADDC/SUBC see the carry
// written by the preceding operation. Shifts step one bit per clock in the
// SHIFT state. The optional iterative multiplier (opcode 0x0F) is built only
// when the macro ALU_MUL_EN is defined; otherwise 0x0F is an illegal opcode.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state
//   bus    alu_seq_if.slave (handshake, operands, result, flags, illegal,
//          state_dbg)
// flags = {Z, C, F, N, L}: zero, carry/borrow, signed overflow,
//         signed-less, unsigned-less.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH) + 1;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_SUBC = 8'h0A;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_LSH  = 8'h0C;
    localparam logic [7:0] OP_RSH  = 8'h0D;
    localparam logic [7:0] OP_ARSH = 8'h0E;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'h0F;
`endif

    typedef enum logic [1:0] {
`ifdef ALU_MUL_EN
        S_MUL   = 2'd2,
`endif
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;

    state_t           state, state_nx;
    logic             accept, in_is_shift;
    logic [SHW-1:0]   in_count, b_cnt;

    // Captured operation; a_q doubles as the shift register in SHIFT and
    // b_q as the multiplier shift register in MUL.
    logic [7:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [SHW-1:0]   cnt;
    logic             exec_q;

    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic             out_valid_q, illegal_q;

    logic [WIDTH-1:0] ex_result, sh_next;
    logic [4:0]       ex_flags;
    logic             ex_emit, ex_illegal, cin;
    logic [WIDTH:0]   wide;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand, acc;
`endif

    assign b_cnt       = bus.b[SHW-1:0];
    assign in_count    = (b_cnt > SHW'(WIDTH)) ? SHW'(WIDTH) : b_cnt;
    assign in_is_shift = (bus.opcode == OP_LSH) || (bus.opcode == OP_RSH) ||
                         (bus.opcode == OP_ARSH);
    assign accept      = bus.in_valid && bus.in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_is_shift && (in_count != '0)) state_nx = S_SHIFT;
`ifdef ALU_MUL_EN
                    else if (bus.opcode == OP_MUL)        state_nx = S_MUL;
`endif
                end
            end
            S_SHIFT: if (cnt == SHW'(1)) state_nx = S_IDLE;
`ifdef ALU_MUL_EN
            S_MUL:   if (cnt == '0)      state_nx = S_IDLE;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.state_dbg = state;
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
        bus.flags     = flags_q;
        bus.illegal   = illegal_q;
    end

    // One step of the active shift, applied to the shift register.
    always_comb begin
        case (op_q)
            OP_LSH:  sh_next = {a_q[WIDTH-2:0], 1'b0};
            OP_RSH:  sh_next = {1'b0, a_q[WIDTH-1:1]};
            default: sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        endcase
    end

    // Single-cycle execute. Flags default to held; each op overwrites only
    // the bits it owns. Shifts only land here with a zero count.
    always_comb begin
        ex_result  = '0;
        ex_flags   = flags_q;
        ex_emit    = 1'b1;
        ex_illegal = 1'b0;
        cin        = ((op_q == OP_ADDC) || (op_q == OP_SUBC)) ? flags_q[3] : 1'b0;
        wide       = '0;
        case (op_q)
            OP_NOP: ex_emit = 1'b0;
            OP_AND: begin ex_result = a_q & b_q; ex_flags[4] = (ex_result == '0); end
            OP_OR:  begin ex_result = a_q | b_q; ex_flags[4] = (ex_result == '0); end
            OP_XOR: begin ex_result = a_q ^ b_q; ex_flags[4] = (ex_result == '0); end
            OP_NOT: begin ex_result = ~a_q;      ex_flags[4] = (ex_result == '0); end
            OP_ADD, OP_ADDC: begin
                wide        = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
                ex_result   = wide[WIDTH-1:0];
                ex_flags[4] = (ex_result == '0);
                ex_flags[3] = wide[WIDTH];
                ex_flags[2] = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (ex_result[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                // Bit WIDTH of the extended difference is the borrow.
                wide        = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
                ex_result   = wide[WIDTH-1:0];
                ex_flags[4] = (ex_result == '0);
                ex_flags[3] = wide[WIDTH];
                ex_flags[2] = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (ex_result[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_CMP: begin
                ex_flags[4] = (a_q == b_q);
                ex_flags[1] = ($signed(a_q) < $signed(b_q));
                ex_flags[0] = (a_q < b_q);
            end
            OP_LSH, OP_RSH, OP_ARSH: begin
                ex_result   = a_q;
                ex_flags[4] = (a_q == '0);
            end
            default: ex_illegal = 1'b1;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= OP_NOP;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            exec_q      <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand       <= '0;
            acc         <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            exec_q      <= 1'b0;

            if (exec_q) begin
                out_valid_q <= ex_emit;
                illegal_q   <= ex_illegal;
                if (ex_emit) begin
                    result_q <= ex_result;
                    flags_q  <= ex_flags;
                end
            end

            if (accept) begin
                op_q   <= bus.opcode;
                a_q    <= bus.a;
                b_q    <= bus.b;
                cnt    <= in_count;
                exec_q <= !(in_is_shift && (in_count != '0));
`ifdef ALU_MUL_EN
                if (bus.opcode == OP_MUL) begin
                    exec_q <= 1'b0;
                    cnt    <= SHW'(WIDTH);
                    mcand  <= {{WIDTH{1'b0}}, bus.a};
                    acc    <= '0;
                end
`endif
            end

            if (state == S_SHIFT) begin
                a_q <= sh_next;
                cnt <= cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    out_valid_q <= 1'b1;
                    result_q    <= sh_next;
                    flags_q[4]  <= (sh_next == '0);
                end
            end

`ifdef ALU_MUL_EN
            // WIDTH partial-product steps, then one edge to publish.
            if (state == S_MUL) begin
                if (cnt != '0) begin
                    if (b_q[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt - SHW'(1);
                end else begin
                    out_valid_q <= 1'b1;
                    result_q    <= acc[WIDTH-1:0];
                    flags_q[4]  <= (acc[WIDTH-1:0] == '0);
                    flags_q[3]  <= |acc[2*WIDTH-1:WIDTH];
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH = 16).
// A reference model computes result/flags/latency for every accepted
// operation; a monitor pops and compares whenever out_valid pulses.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    localparam int WIDTH = 16;
    localparam int SHW   = $clog2(WIDTH) + 1;
    localparam int EW    = WIDTH + 6;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_SUBC = 8'h0A;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_LSH  = 8'h0C;
    localparam logic [7:0] OP_RSH  = 8'h0D;
    localparam logic [7:0] OP_ARSH = 8'h0E;
    localparam logic [7:0] OP_MUL  = 8'h0F;

    logic clk;
    logic reset;
    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [4:0]    m_flags = 5'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [EW-1:0] mon_e;
    int            mon_c;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    check("result_flags_illegal", {bus.result, bus.flags, bus.illegal}, mon_e);
                    check("latency", cyc, mon_c);
                end
            end else if (bus.illegal) begin
                check("illegal_without_valid", 1, 0);
            end
        end
    end

    // Reference model: updates m_flags, returns packed {result, flags, illegal}
    // and the number of edges from accept to out_valid.
    task automatic model(input logic [7:0] op, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, output logic push,
                         output logic [EW-1:0] e, output int lat);
        logic z, c, f, n, l, ill, cinb;
        logic [WIDTH-1:0]   r;
        logic [2*WIDTH-1:0] p;
        int cnt, wide, sw;
        {z, c, f, n, l} = m_flags;
        r = '0; ill = 1'b0; push = 1'b1; lat = 1;
        cnt = int'(bv[SHW-1:0]);
        if (cnt > WIDTH) cnt = WIDTH;
        case (op)
            OP_NOP: push = 1'b0;
            OP_AND: begin r = av & bv; z = (r == 0); end
            OP_OR:  begin r = av | bv; z = (r == 0); end
            OP_XOR: begin r = av ^ bv; z = (r == 0); end
            OP_NOT: begin r = ~av;     z = (r == 0); end
            OP_ADD, OP_ADDC: begin
                cinb = (op == OP_ADDC) ? c : 1'b0;
                wide = int'(av) + int'(bv) + int'(cinb);
                sw   = int'($signed(av)) + int'($signed(bv)) + int'(cinb);
                r = wide[WIDTH-1:0];
                c = (wide > 32'h0000_FFFF);
                f = (sw > 32767) || (sw < -32768);
                z = (r == 0);
            end
            OP_SUB, OP_SUBC: begin
                cinb = (op == OP_SUBC) ? c : 1'b0;
                wide = int'(av) - int'(bv) - int'(cinb);
                sw   = int'($signed(av)) - int'($signed(bv)) - int'(cinb);
                r = wide[WIDTH-1:0];
                c = (wide < 0);
                f = (sw > 32767) || (sw < -32768);
                z = (r == 0);
            end
            OP_CMP: begin
                z = (av == bv);
                n = ($signed(av) < $signed(bv));
                l = (av < bv);
            end
            OP_LSH, OP_RSH, OP_ARSH: begin
                if (op == OP_LSH)      r = (cnt >= WIDTH) ? '0 : (av << cnt);
                else if (op == OP_RSH) r = (cnt >= WIDTH) ? '0 : (av >> cnt);
                else                   r = (cnt >= WIDTH) ? {WIDTH{av[WIDTH-1]}}
                                                          : WIDTH'($signed(av) >>> cnt);
                z = (r == 0);
                lat = (cnt == 0) ? 1 : cnt;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                p = {{WIDTH{1'b0}}, av} * {{WIDTH{1'b0}}, bv};
                r = p[WIDTH-1:0];
                z = (r == 0);
                c = (p[2*WIDTH-1:WIDTH] != 0);
                lat = WIDTH + 1;
            end
`endif
            default: ill = 1'b1;
        endcase
        m_flags = {z, c, f, n, l};
        e = {r, m_flags, ill};
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [7:0] op, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv);
        int waited = 0;
        logic push;
        logic [EW-1:0] e;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = av;
        bus.b        = bv;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        model(op, av, bv, push, e, lat);
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc + lat);
        end
    endtask

    task automatic drain(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0]       rand_ops [0:13];
    logic [7:0]       r_op;
    logic [WIDTH-1:0] r_b;

    // ---------------- stimulus ----------------
    initial begin
        rand_ops = '{OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDC,
                     OP_SUB, OP_SUBC, OP_CMP, OP_LSH, OP_RSH, OP_ARSH, 8'h06};
        bus.in_valid = 1'b0;
        bus.opcode   = 8'h00;
        bus.a        = '0;
        bus.b        = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result",    bus.result,    0);
        check("rst_flags",     bus.flags,     0);
        check("rst_illegal",   bus.illegal,   0);
        check("rst_state",     bus.state_dbg, 0);
        reset = 1'b0;
        @(negedge clk);

        // Signed overflow on ADD.
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        drain(3);
        check("add_ovf_result", bus.result, 16'h8000);
        check("add_ovf_flags",  bus.flags,  5'b00100);

        // Carry out and zero.
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        drain(3);
        check("add_carry_result", bus.result, 16'h0000);
        check("add_carry_flags",  bus.flags,  5'b11000);

        // Back-to-back carry chain.
        issue(OP_ADD,  16'hFFFF, 16'h0002);
        issue(OP_ADDC, 16'h0000, 16'h0000);
        drain(3);
        check("addc_chain_result", bus.result, 16'h0001);
        check("addc_chain_flags",  bus.flags,  5'b00000);

        // CMP holds C and F (C set first).
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        issue(OP_CMP, 16'hFFFF, 16'h0001);
        drain(3);
        check("cmp1_result", bus.result, 16'h0000);
        check("cmp1_flags",  bus.flags,  5'b01010);
        issue(OP_CMP, 16'h0001, 16'hFFFF);
        drain(3);
        check("cmp2_flags",  bus.flags,  5'b01001);

        // ARSH by 4: in_ready low for exactly 4 cycles.
        issue(OP_ARSH, 16'h8000, 16'h0004);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("arsh_ready_low", bus.in_ready, 0);
        end
        @(negedge clk);
        check("arsh_ready_back", bus.in_ready, 1);
        check("arsh_result",     bus.result,   16'hF800);

        // Reset two cycles into a count-10 LSH.
        issue(OP_LSH, 16'h0F0F, 16'd10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_in_ready",  bus.in_ready,  1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_result",    bus.result,    0);
        check("midrst_flags",     bus.flags,     0);
        check("midrst_illegal",   bus.illegal,   0);
        exp_q.delete();
        exp_cyc_q.delete();
        m_flags = 5'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);

        // RSH with count field 31 saturates at WIDTH.
        issue(OP_RSH, 16'hABCD, 16'd31);
        drain(20);
        check("rsh31_result", bus.result, 16'h0000);

        // Zero-count shift passes a through in one cycle.
        issue(OP_LSH, 16'h1234, 16'h0000);
        drain(3);
        check("lsh0_result", bus.result, 16'h1234);

        // Undefined opcode.
        issue(8'h3C, 16'h5555, 16'h0003);
        drain(3);
        check("illegal_result", bus.result, 16'h0000);

`ifdef ALU_MUL_EN
        issue(OP_MUL, 16'h0100, 16'h0100);
        drain(20);
        check("mul_result", bus.result,     16'h0000);
        check("mul_zc",     bus.flags[4:3], 2'b11);
`else
        issue(OP_LSH, 16'h00F0, 16'h0000);
        issue(OP_MUL, 16'h0100, 16'h0100);
        drain(3);
        check("op0f_result", bus.result, 16'h0000);
`endif

        // Random mix, mostly back-to-back.
        for (int i = 0; i < 60; i++) begin
            r_op = rand_ops[$urandom_range(0, 13)];
            r_b  = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 20))
                                               : WIDTH'($urandom);
            issue(r_op, WIDTH'($urandom), r_b);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        drain(40);
        check("pending_results", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
